// File: rtl/axi_lite_pkg.sv
// Shared constants, FSM encodings and decode helper for the AXI4-Lite 1-to-N crossbar.
package axi_lite_pkg;

    // Two-bit codes; callers zero-extend to their RESP_WIDTH.
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA, R_ERR} rstate_e;

    function automatic logic slot_unmapped(input int unsigned slot, input int unsigned nports);
        return slot >= nports;
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Address to downstream-port decoder: port index plus an unmapped flag.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int SLOT_LSB   = 4,
    parameter int NUM_MPORTS = 2,
    parameter int IDX_W      = (NUM_MPORTS > 1) ? $clog2(NUM_MPORTS) : 1
)(
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_unmapped
);

    logic [ADDR_WIDTH-1:0] w_slot;

    assign w_slot     = i_addr >> SLOT_LSB;
    assign o_idx      = w_slot[IDX_W-1:0];
    assign o_unmapped = slot_unmapped(32'(w_slot), $unsigned(NUM_MPORTS));

endmodule

// File: rtl/axi_lite_xbar_1ton.sv
// AXI4-Lite 1-to-N address-decoding interconnect with independent read and write engines.
module axi_lite_xbar_1ton
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_MPORTS = 2,
    parameter int SLOT_LSB   = 4,
    parameter int STRB_WIDTH = DATA_WIDTH/8
)(
    input  logic                             axi_aclk,
    input  logic                             axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
    input  logic                             s0_axi_awvalid,
    output logic                             s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
    input  logic [STRB_WIDTH-1:0]            s0_axi_wstrb,
    input  logic                             s0_axi_wvalid,
    output logic                             s0_axi_wready,
    output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
    output logic                             s0_axi_bvalid,
    input  logic                             s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
    input  logic                             s0_axi_arvalid,
    output logic                             s0_axi_arready,
    output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
    output logic                             s0_axi_rvalid,
    input  logic                             s0_axi_rready,
    output logic [NUM_MPORTS*ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [NUM_MPORTS-1:0]            m_axi_awvalid,
    input  logic [NUM_MPORTS-1:0]            m_axi_awready,
    output logic [NUM_MPORTS*DATA_WIDTH-1:0] m_axi_wdata,
    output logic [NUM_MPORTS*STRB_WIDTH-1:0] m_axi_wstrb,
    output logic [NUM_MPORTS-1:0]            m_axi_wvalid,
    input  logic [NUM_MPORTS-1:0]            m_axi_wready,
    input  logic [NUM_MPORTS*RESP_WIDTH-1:0] m_axi_bresp,
    input  logic [NUM_MPORTS-1:0]            m_axi_bvalid,
    output logic [NUM_MPORTS-1:0]            m_axi_bready,
    output logic [NUM_MPORTS*ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [NUM_MPORTS-1:0]            m_axi_arvalid,
    input  logic [NUM_MPORTS-1:0]            m_axi_arready,
    input  logic [NUM_MPORTS*DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [NUM_MPORTS*RESP_WIDTH-1:0] m_axi_rresp,
    input  logic [NUM_MPORTS-1:0]            m_axi_rvalid,
    output logic [NUM_MPORTS-1:0]            m_axi_rready
);

    localparam int IDX_W = (NUM_MPORTS > 1) ? $clog2(NUM_MPORTS) : 1;
    localparam logic [RESP_WIDTH-1:0] R_OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] R_DECERR = RESP_WIDTH'(RESP_DECERR);

    logic [NUM_MPORTS-1:0][RESP_WIDTH-1:0] w_m_bresp, w_m_rresp;
    logic [NUM_MPORTS-1:0][DATA_WIDTH-1:0] w_m_rdata;

    assign w_m_bresp = m_axi_bresp;
    assign w_m_rresp = m_axi_rresp;
    assign w_m_rdata = m_axi_rdata;

    // Readies stay low until the first clock after reset release.
    logic r_live;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_live <= 1'b0;
        else              r_live <= 1'b1;
    end

    // ---------------- write engine ----------------
    wstate_e               r_wstate, w_wstate_nx;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [IDX_W-1:0]      r_widx, w_aw_idx;
    logic                  r_aw_pend, r_w_pend, r_bvalid;
    logic [RESP_WIDTH-1:0] r_bresp;
    logic                  w_aw_unmapped, w_aw_acc, w_aw_hs, w_w_hs, w_b_cap;
    logic [NUM_MPORTS-1:0] w_m_awvalid, w_m_wvalid, w_m_bready;

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLOT_LSB   (SLOT_LSB),
        .NUM_MPORTS (NUM_MPORTS),
        .IDX_W      (IDX_W)
    ) u_aw_dec (
        .i_addr     (s0_axi_awaddr),
        .o_idx      (w_aw_idx),
        .o_unmapped (w_aw_unmapped)
    );

    always_comb begin
        w_wstate_nx = r_wstate;
        w_aw_acc    = 1'b0;
        w_aw_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_b_cap     = 1'b0;
        w_m_awvalid = '0;
        w_m_wvalid  = '0;
        w_m_bready  = '0;
        case (r_wstate)
            W_IDLE: begin
                w_aw_acc = r_live && s0_axi_awvalid && s0_axi_wvalid;
                if (w_aw_acc) w_wstate_nx = w_aw_unmapped ? W_ERR : W_FWD;
            end
            W_FWD: begin
                w_m_awvalid[r_widx] = r_aw_pend;
                w_m_wvalid[r_widx]  = r_w_pend;
                w_aw_hs = r_aw_pend && m_axi_awready[r_widx];
                w_w_hs  = r_w_pend && m_axi_wready[r_widx];
                if ((!r_aw_pend || w_aw_hs) && (!r_w_pend || w_w_hs)) w_wstate_nx = W_RESP;
            end
            W_RESP: begin
                w_m_bready[r_widx] = !r_bvalid;
                w_b_cap = !r_bvalid && m_axi_bvalid[r_widx];
                if (r_bvalid && s0_axi_bready) w_wstate_nx = W_IDLE;
            end
            W_ERR: if (r_bvalid && s0_axi_bready) w_wstate_nx = W_IDLE;
            default: w_wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_wstate <= W_IDLE;
        else              r_wstate <= w_wstate_nx;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_widx    <= '0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= R_OKAY;
        end else begin
            if (w_aw_acc) begin
                r_awaddr  <= s0_axi_awaddr;
                r_wdata   <= s0_axi_wdata;
                r_wstrb   <= s0_axi_wstrb;
                r_widx    <= w_aw_idx;
                r_aw_pend <= !w_aw_unmapped;
                r_w_pend  <= !w_aw_unmapped;
                // Unmapped writes answer immediately without touching any port.
                r_bvalid  <= w_aw_unmapped;
                r_bresp   <= w_aw_unmapped ? R_DECERR : R_OKAY;
            end
            if (w_aw_hs) r_aw_pend <= 1'b0;
            if (w_w_hs)  r_w_pend  <= 1'b0;
            if (w_b_cap) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_m_bresp[r_widx];
            end else if (r_bvalid && s0_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign s0_axi_awready = w_aw_acc;
    assign s0_axi_wready  = w_aw_acc;
    assign s0_axi_bvalid  = r_bvalid;
    assign s0_axi_bresp   = r_bresp;
    assign m_axi_awaddr   = {NUM_MPORTS{r_awaddr}};
    assign m_axi_wdata    = {NUM_MPORTS{r_wdata}};
    assign m_axi_wstrb    = {NUM_MPORTS{r_wstrb}};
    assign m_axi_awvalid  = w_m_awvalid;
    assign m_axi_wvalid   = w_m_wvalid;
    assign m_axi_bready   = w_m_bready;

    // ---------------- read engine ----------------
    rstate_e               r_rstate, w_rstate_nx;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [IDX_W-1:0]      r_ridx, w_ar_idx;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [RESP_WIDTH-1:0] r_rresp;
    logic                  w_ar_unmapped, w_ar_acc, w_arready, w_r_cap;
    logic [NUM_MPORTS-1:0] w_m_arvalid, w_m_rready;

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLOT_LSB   (SLOT_LSB),
        .NUM_MPORTS (NUM_MPORTS),
        .IDX_W      (IDX_W)
    ) u_ar_dec (
        .i_addr     (s0_axi_araddr),
        .o_idx      (w_ar_idx),
        .o_unmapped (w_ar_unmapped)
    );

    always_comb begin
        w_rstate_nx = r_rstate;
        w_arready   = 1'b0;
        w_ar_acc    = 1'b0;
        w_r_cap     = 1'b0;
        w_m_arvalid = '0;
        w_m_rready  = '0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_live;
                w_ar_acc  = r_live && s0_axi_arvalid;
                if (w_ar_acc) w_rstate_nx = w_ar_unmapped ? R_ERR : R_FWD;
            end
            R_FWD: begin
                w_m_arvalid[r_ridx] = 1'b1;
                if (m_axi_arready[r_ridx]) w_rstate_nx = R_DATA;
            end
            R_DATA: begin
                w_m_rready[r_ridx] = !r_rvalid;
                w_r_cap = !r_rvalid && m_axi_rvalid[r_ridx];
                if (r_rvalid && s0_axi_rready) w_rstate_nx = R_IDLE;
            end
            R_ERR: if (r_rvalid && s0_axi_rready) w_rstate_nx = R_IDLE;
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_rstate <= R_IDLE;
        else              r_rstate <= w_rstate_nx;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_araddr <= '0;
            r_ridx   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= R_OKAY;
        end else begin
            if (w_ar_acc) begin
                r_araddr <= s0_axi_araddr;
                r_ridx   <= w_ar_idx;
                r_rvalid <= w_ar_unmapped;
                r_rdata  <= '0;
                r_rresp  <= w_ar_unmapped ? R_DECERR : R_OKAY;
            end
            if (w_r_cap) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_m_rdata[r_ridx];
                r_rresp  <= w_m_rresp[r_ridx];
            end else if (r_rvalid && s0_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s0_axi_arready = w_arready;
    assign s0_axi_rvalid  = r_rvalid;
    assign s0_axi_rdata   = r_rdata;
    assign s0_axi_rresp   = r_rresp;
    assign m_axi_araddr   = {NUM_MPORTS{r_araddr}};
    assign m_axi_arvalid  = w_m_arvalid;
    assign m_axi_rready   = w_m_rready;

endmodule
